// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-side bundle between the transmit FIFO and the UART transmit stage.
// master = reader (pops words), slave = FIFO (presents the head word).
interface uart_tx_fifo_drain_if #(
  parameter int DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_rdata;
  logic            fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from a show-ahead FIFO and frames them.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_drain #(
  parameter int DBIT   = 8,
  parameter int SB     = 1,
  parameter int DVSR   = 434,
  parameter int DVSR_W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_fifo_drain_if.master  fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int BIT_W = $clog2(DBIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_reg, state_next;
  logic [DVSR_W-1:0] tick_reg, tick_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [DBIT-1:0]   shreg_reg, shreg_next;
  logic              tx_reg, tx_next;
  logic              tick_last;
`ifdef UART_TX_PARITY_EN
  logic              parity_reg, parity_next;
`endif

  assign tick_last = (tick_reg == DVSR_W'(DVSR - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      bit_reg    <= '0;
      shreg_reg  <= '0;
      tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      bit_reg    <= bit_next;
      shreg_reg  <= shreg_next;
      tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_next     = bit_reg;
    shreg_next   = shreg_reg;
    fifo.fifo_rd = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (!fifo.fifo_empty) begin
          fifo.fifo_rd = 1'b1;
          shreg_next   = fifo.fifo_rdata;
          tick_next    = '0;
          state_next   = START;
`ifdef UART_TX_PARITY_EN
          // Parity is latched from the original word; shreg is consumed by shifting.
          parity_next  = ^fifo.fifo_rdata;
`endif
        end
      end

      START: begin
        if (tick_last) begin
          tick_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          tick_next = tick_reg + DVSR_W'(1);
        end
      end

      DATA: begin
        if (tick_last) begin
          tick_next  = '0;
          shreg_next = shreg_reg >> 1;
          if (bit_reg == BIT_W'(DBIT - 1)) begin
            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end else begin
          tick_next = tick_reg + DVSR_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_last) begin
          tick_next  = '0;
          bit_next   = '0;
          state_next = STOP;
        end else begin
          tick_next = tick_reg + DVSR_W'(1);
        end
      end
`endif

      STOP: begin
        if (tick_last) begin
          tick_next = '0;
          if (bit_reg == BIT_W'(SB - 1)) begin
            bit_next     = '0;
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end else begin
          tick_next = tick_reg + DVSR_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line level is precomputed from the next state so tx comes straight off a flop.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Serial transmit stage that drains bytes from the transmit FIFO and shifts each one out as an asynchronous UART frame. The frame is a start bit, DBIT data bits LSB first, an optional even-parity bit, and SB stop bits. It sits directly downstream of the FIFO and consumes its `empty`/`rd`/`rdata` interface, in which the head word is presented combinationally and `rd` pops it. The output `tx` drives the board pin.

## Interface
- DBIT, 8, data bits per frame.
- SB, 1, stop bits per frame (1 or 2).
- DVSR, 434, clk cycles per bit period (≥2).
- DVSR_W, 9, width of bit-period counter; must satisfy 2**DVSR_W > DVSR.

- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DBIT  FIFO head word, valid whenever fifo_empty=0.
- fifo_rd  out  1  pop strobe to FIFO, one cycle per word.
- tx  out  1  serial line, idle high, registered.
- tx_busy  out  1  high from start bit through last stop bit.
- tx_done_tick  out  1  one-cycle pulse at end of each frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with macro), STOP.
- Counters:
  - `tick_cnt`: 0..DVSR-1, counts clk cycles within a bit.
  - `bit_cnt`: 0..DBIT-1 in DATA, 0..SB-1 in STOP.
- `shreg`: DBIT-bit shift register holding the word in flight.
- IDLE:
  - `tx`=1, `tx_busy`=0.
  - If fifo_empty=0: `fifo_rd`=1 combinationally this cycle, `shreg` <= fifo_rdata, `tick_cnt` <= 0, next state START.
  - Otherwise stay in IDLE, `fifo_rd`=0.
- START: `tx`=0 for DVSR cycles, then DATA with `bit_cnt`=0.
- DATA:
  - `tx`=shreg[0].
  - When `tick_cnt`=DVSR-1: shift right, `tick_cnt` <= 0, `bit_cnt`++.
  - After bit DBIT-1, go to PARITY (macro defined) or STOP.
- PARITY: `tx`=XOR of the original word (even parity), held DVSR cycles, then STOP.
- STOP:
  - `tx`=1 for SB×DVSR cycles.
  - On the final cycle, `tx_done_tick`=1 and next state IDLE.
- `fifo_rd` is asserted only in IDLE with fifo_empty=0. It is never asserted while busy, regardless of fifo_empty activity.
- The next frame always begins from IDLE. The minimum inter-frame idle is exactly 1 clk with `tx`=1.
- `tx` is driven from a register. The start bit appears on the clk edge that samples `fifo_rd`=1.
- Reset mid-frame:
  - All state returns to IDLE immediately and `tx` returns to 1.
  - The word in flight is discarded; the FIFO is not re-read for it.

## Timing
- Reset values: tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0. State IDLE, all counters 0.
- Pop to start bit: `fifo_rd` high in cycle N; `tx`=0 from cycle N+1.
- Frame length: (1 + DBIT + P + SB)×DVSR cycles, where P=1 with macro and 0 without.
- `tx_done_tick`: in the last cycle of the final stop bit.
- Back-to-back throughput: one frame per frame length + 1 cycles.
- `tx_busy`: high from cycle N+1 through the `tx_done_tick` cycle inclusive.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state and its bit are compiled in; even parity after the data bits.
  - Undefined: the PARITY state and logic are absent; STOP follows DATA directly.

## Test plan
- DVSR=4, DBIT=8, SB=1, no macro; FIFO holds 0xA5 → one `fifo_rd` pulse, then `tx` levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `tx_done_tick` falls in cycle 40 after the pop.
- FIFO empty for 200 cycles → `tx`=1, `fifo_rd`=0, `tx_busy`=0 throughout.
- FIFO holds 0x01 then 0xFF → two `fifo_rd` pulses 41 cycles apart, with exactly 1 idle-high cycle between frames. Data bits are correct for both.
- Reset asserted at data bit 3 of 0x3C → `tx`=1 and `tx_busy`=0 immediately. No further `fifo_rd` while the FIFO is empty after release.
- Macro defined, DVSR=4: 0xA5 → parity bit 0; 0x07 → parity bit 1. Frame length is 44 cycles.
- SB=2, DVSR=4: 0x00 → stop high for 8 cycles. `tx_done_tick` falls on the last of those 8 cycles.
